// File: rtl/ipg_rx_if.sv
// ---------------------------------------------------------------------------
// ipg_rx_if
// Bundles every non-clock signal of ipg_rx.
//   encoded_rx_*        : decoded 66-bit block stream from the 64b/66b decoder
//   proced_encoded_rx_* : block stream toward the MAC (IPG blocks replaced by idle)
//   ipg_req_*           : request FIFO head (first-word-fall-through) + pop
//   ipg_mem_*           : memory FIFO head (first-word-fall-through) + pop
//   frame_err_cnt       : saturating protocol-error count
//   drop_cnt            : saturating count of IPG blocks lost to a full FIFO
// Modports: slave = ipg_rx side, master = the environment driving it.
// ---------------------------------------------------------------------------
interface ipg_rx_if;
  logic        encoded_rx_valid;
  logic [1:0]  encoded_rx_hdr;
  logic [63:0] encoded_rx_data;

  logic        proced_encoded_rx_valid;
  logic [1:0]  proced_encoded_rx_hdr;
  logic [63:0] proced_encoded_rx_data;

  logic        ipg_req_valid;
  logic        ipg_req_ready;
  logic [63:0] ipg_req_chunk;

  logic        ipg_mem_valid;
  logic        ipg_mem_ready;
  logic [63:0] ipg_mem_chunk;

  logic [15:0] frame_err_cnt;
  logic [15:0] drop_cnt;

  modport slave (
    input  encoded_rx_valid, encoded_rx_hdr, encoded_rx_data,
    input  ipg_req_ready, ipg_mem_ready,
    output proced_encoded_rx_valid, proced_encoded_rx_hdr, proced_encoded_rx_data,
    output ipg_req_valid, ipg_req_chunk, ipg_mem_valid, ipg_mem_chunk,
    output frame_err_cnt, drop_cnt
  );

  modport master (
    output encoded_rx_valid, encoded_rx_hdr, encoded_rx_data,
    output ipg_req_ready, ipg_mem_ready,
    input  proced_encoded_rx_valid, proced_encoded_rx_hdr, proced_encoded_rx_data,
    input  ipg_req_valid, ipg_req_chunk, ipg_mem_valid, ipg_mem_chunk,
    input  frame_err_cnt, drop_cnt
  );
endinterface

// File: rtl/ipg_rx.sv
// ---------------------------------------------------------------------------
// ipg_rx
// Receive-side IPG demux between the 64b/66b decoder and the MAC RX path.
// Out-of-frame IPG request/memory control blocks are pulled into their own
// FIFOs and replaced by an idle block; everything else passes through with a
// fixed one-cycle register delay. A small frame FSM tracks start/terminate
// blocks to tell in-frame from out-of-frame and counts protocol errors.
// Ports:
//   clk   : single clock
//   reset : asynchronous, active-high
//   bus   : ipg_rx_if.slave (block in/out, two FIFO heads, two counters)
// ---------------------------------------------------------------------------

// Single-clock FWFT FIFO of 64-bit words. drop_o flags a write that could
// not be accepted because the FIFO was full with no pop in the same cycle.
module ipg_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [63:0] wr_data_i,
  input  logic        rd_ready_i,
  output logic        rd_valid_o,
  output logic [63:0] rd_data_o,
  output logic        drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [63:0] mem_q [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd_ready_i && !empty;
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign push   = wr_en_i && (!full || pop);
  assign drop_o = wr_en_i && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

module ipg_rx #(
  parameter logic [7:0] REQ_TYPE  = 8'hA5,
  parameter logic [7:0] MEM_TYPE  = 8'h5A,
  parameter int         REQ_DEPTH = 8,
  parameter int         MEM_DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  ipg_rx_if.slave  bus
);
  localparam logic [1:0]  HDR_DATA   = 2'b10;
  localparam logic [1:0]  HDR_CTRL   = 2'b01;
  localparam logic [63:0] IDLE_BLOCK = 64'h1E;

  typedef enum logic {S_IDLE, S_IN_FRAME} state_e;

  state_e      state_q, state_d;
  logic        valid_q;
  logic [1:0]  hdr_q, hdr_d;
  logic [63:0] data_q, data_d;
  logic [15:0] frame_err_q, drop_q;
  logic        req_wr, mem_wr, proto_err, req_drop, mem_drop;
  logic [7:0]  blk_type;
  logic        is_ctrl, is_start, is_term, is_ipg;

  assign blk_type = bus.encoded_rx_data[7:0];
  assign is_ctrl  = bus.encoded_rx_valid && (bus.encoded_rx_hdr == HDR_CTRL);
  assign is_start = blk_type inside {8'h78, 8'h33, 8'h66};
  assign is_term  = blk_type inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                     8'hCC, 8'hD2, 8'hE1, 8'hFF};
  assign is_ipg   = (blk_type == REQ_TYPE) || (blk_type == MEM_TYPE);

  // Frame FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Frame FSM: next state. Only valid control blocks move it.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    if (is_ctrl) begin
      unique case (state_q)
        S_IDLE:     if (is_start) state_d = S_IN_FRAME;
        S_IN_FRAME: if (is_term)  state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Frame FSM: outputs -- outgoing block, FIFO writes, error strobe.
  always_comb begin
    hdr_d     = bus.encoded_rx_hdr;
    data_d    = bus.encoded_rx_data;
    req_wr    = 1'b0;
    mem_wr    = 1'b0;
    proto_err = 1'b0;
    if (bus.encoded_rx_valid) begin
      case (bus.encoded_rx_hdr)
        HDR_CTRL: begin
          if (state_q == S_IDLE && is_ipg) begin
            hdr_d  = HDR_CTRL;
            data_d = IDLE_BLOCK;
            req_wr = (blk_type == REQ_TYPE);
            mem_wr = (blk_type == MEM_TYPE);
          end else if (state_q == S_IN_FRAME && (is_start || is_ipg)) begin
            proto_err = 1'b1;
          end
        end
        HDR_DATA: proto_err = (state_q == S_IDLE);
        default:  proto_err = 1'b1;
      endcase
    end
  end

  // Output block register; hdr/data hold across invalid cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      hdr_q   <= HDR_CTRL;
      data_q  <= IDLE_BLOCK;
    end else begin
      valid_q <= bus.encoded_rx_valid;
      if (bus.encoded_rx_valid) begin
        hdr_q  <= hdr_d;
        data_q <= data_d;
      end
    end
  end

  // Saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= '0;
      drop_q      <= '0;
    end else begin
      if (proto_err && frame_err_q != 16'hFFFF)          frame_err_q <= frame_err_q + 16'd1;
      if ((req_drop || mem_drop) && drop_q != 16'hFFFF) drop_q      <= drop_q + 16'd1;
    end
  end

  ipg_rx_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (req_wr),
    .wr_data_i  (bus.encoded_rx_data),
    .rd_ready_i (bus.ipg_req_ready),
    .rd_valid_o (bus.ipg_req_valid),
    .rd_data_o  (bus.ipg_req_chunk),
    .drop_o     (req_drop)
  );

  ipg_rx_fifo #(.DEPTH(MEM_DEPTH)) u_mem_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (mem_wr),
    .wr_data_i  (bus.encoded_rx_data),
    .rd_ready_i (bus.ipg_mem_ready),
    .rd_valid_o (bus.ipg_mem_valid),
    .rd_data_o  (bus.ipg_mem_chunk),
    .drop_o     (mem_drop)
  );

  assign bus.proced_encoded_rx_valid = valid_q;
  assign bus.proced_encoded_rx_hdr   = hdr_q;
  assign bus.proced_encoded_rx_data  = data_q;
  assign bus.frame_err_cnt           = frame_err_q;
  assign bus.drop_cnt                = drop_q;
endmodule

// File: tb/tb_ipg_rx.sv
// ---------------------------------------------------------------------------
// tb_ipg_rx
// Directed scenarios plus a randomized run for ipg_rx. A queue-based model
// of the receive rules predicts every output; inputs change 1 ns after each
// rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_ipg_rx;
  localparam logic [63:0] IDLE = 64'h1E;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ipg_rx_if bus();
  ipg_rx u_dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_in_frame;
  logic [63:0] m_req[$];
  logic [63:0] m_mem[$];
  int          m_err, m_drop;
  logic        m_valid;
  logic [1:0]  m_hdr;
  logic [63:0] m_data;

  task automatic model_reset();
    m_in_frame = 0; m_req.delete(); m_mem.delete();
    m_err = 0; m_drop = 0; m_valid = 0; m_hdr = 2'b01; m_data = IDLE;
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One block period of receive behaviour, applied to the pre-edge inputs.
  task automatic model_step(input bit v, input logic [1:0] h, input logic [63:0] d,
                            input bit rr, input bit mr);
    logic [7:0] t;
    bit start, term, ipg;
    t = d[7:0];
    start = (t == 8'h78) || (t == 8'h33) || (t == 8'h66);
    term  = (t == 8'h87) || (t == 8'h99) || (t == 8'hAA) || (t == 8'hB4) ||
            (t == 8'hCC) || (t == 8'hD2) || (t == 8'hE1) || (t == 8'hFF);
    ipg   = (t == 8'hA5) || (t == 8'h5A);
    if (rr && m_req.size() > 0) void'(m_req.pop_front());
    if (mr && m_mem.size() > 0) void'(m_mem.pop_front());
    m_valid = v;
    if (v) begin
      m_hdr = h; m_data = d;
      if (h == 2'b01) begin
        if (!m_in_frame && ipg) begin
          m_data = IDLE;
          if (t == 8'hA5) begin
            if (m_req.size() < DEPTH) m_req.push_back(d); else m_drop = sat(m_drop);
          end else begin
            if (m_mem.size() < DEPTH) m_mem.push_back(d); else m_drop = sat(m_drop);
          end
        end else if (m_in_frame) begin
          if (start || ipg) m_err = sat(m_err);
          else if (term) m_in_frame = 0;
        end else if (start) begin
          m_in_frame = 1;
        end
      end else if (h == 2'b10) begin
        if (!m_in_frame) m_err = sat(m_err);
      end else begin
        m_err = sat(m_err);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] h, input logic [63:0] d,
                       input bit rr = 0, input bit mr = 0);
    bus.encoded_rx_valid = v;
    bus.encoded_rx_hdr   = h;
    bus.encoded_rx_data  = d;
    bus.ipg_req_ready    = rr;
    bus.ipg_mem_ready    = mr;
    model_step(v, h, d, rr, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.encoded_rx_valid = 0; bus.ipg_req_ready = 0; bus.ipg_mem_ready = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  function automatic logic [63:0] rnd_block(input logic [7:0] t);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[7:0] = t;
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (bus.proced_encoded_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", bus.proced_encoded_rx_valid); end
    checks++; if (bus.proced_encoded_rx_hdr !== 2'b01) begin errors++; $display("FAIL reset_hdr got %0h want 1", bus.proced_encoded_rx_hdr); end
    checks++; if (bus.proced_encoded_rx_data !== IDLE) begin errors++; $display("FAIL reset_data got %h want %h", bus.proced_encoded_rx_data, IDLE); end
    checks++; if (bus.ipg_req_valid !== 1'b0 || bus.ipg_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_fifo_valid got %0b%0b want 00", bus.ipg_req_valid, bus.ipg_mem_valid); end
    checks++; if (bus.ipg_req_chunk !== 64'h0 || bus.ipg_mem_chunk !== 64'h0) begin errors++; $display("FAIL reset_chunk got %h/%h want 0", bus.ipg_req_chunk, bus.ipg_mem_chunk); end
    checks++; if (bus.frame_err_cnt !== 16'h0 || bus.drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.frame_err_cnt, bus.drop_cnt); end
  endtask

  task automatic test_extract();
    logic [63:0] p;
    p = 64'h11223344556677A5;
    do_reset();
    drive(1, 2'b01, IDLE);
    checks++; if (bus.proced_encoded_rx_valid !== 1'b1 || bus.proced_encoded_rx_hdr !== 2'b01 || bus.proced_encoded_rx_data !== IDLE) begin errors++; $display("FAIL idle_pass got %0b/%0h/%h want 1/1/%h", bus.proced_encoded_rx_valid, bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, IDLE); end
    drive(1, 2'b01, p);
    checks++; if (bus.proced_encoded_rx_hdr !== 2'b01 || bus.proced_encoded_rx_data !== IDLE) begin errors++; $display("FAIL extract_out got %0h/%h want 1/%h", bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, IDLE); end
    checks++; if (bus.ipg_req_valid !== 1'b1 || bus.ipg_req_chunk !== p) begin errors++; $display("FAIL extract_req got %0b/%h want 1/%h", bus.ipg_req_valid, bus.ipg_req_chunk, p); end
    checks++; if (bus.ipg_mem_valid !== 1'b0) begin errors++; $display("FAIL extract_mem_empty got %0b want 0", bus.ipg_mem_valid); end
  endtask

  task automatic test_in_frame();
    logic [1:0]  hs [4];
    logic [63:0] ds [4];
    do_reset();
    hs = '{2'b01, 2'b10, 2'b01, 2'b01};
    ds = '{rnd_block(8'h78), {$urandom, $urandom}, rnd_block(8'hA5), rnd_block(8'h87)};
    for (int i = 0; i < 4; i++) begin
      drive(1, hs[i], ds[i]);
      checks++; if (bus.proced_encoded_rx_hdr !== hs[i] || bus.proced_encoded_rx_data !== ds[i]) begin errors++; $display("FAIL frame_pass%0d got %0h/%h want %0h/%h", i, bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, hs[i], ds[i]); end
    end
    checks++; if (bus.ipg_req_valid !== 1'b0) begin errors++; $display("FAIL frame_req_empty got %0b want 0", bus.ipg_req_valid); end
    checks++; if (bus.frame_err_cnt !== 16'd1) begin errors++; $display("FAIL frame_err got %0d want 1", bus.frame_err_cnt); end
  endtask

  // Fill the memory FIFO past full, then overwrite-on-pop and drain across wrap.
  task automatic test_mem_overflow_and_wrap();
    logic [63:0] exp [9];
    logic [63:0] extra;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp[i] = rnd_block(8'h5A);
      drive(1, 2'b01, exp[i]);
    end
    checks++; if (bus.proced_encoded_rx_data !== IDLE) begin errors++; $display("FAIL ovf_out got %h want %h", bus.proced_encoded_rx_data, IDLE); end
    checks++; if (bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", bus.drop_cnt); end
    checks++; if (bus.ipg_mem_valid !== 1'b1 || bus.ipg_mem_chunk !== exp[0]) begin errors++; $display("FAIL ovf_head got %0b/%h want 1/%h", bus.ipg_mem_valid, bus.ipg_mem_chunk, exp[0]); end
    extra = rnd_block(8'h5A);
    drive(1, 2'b01, extra, 0, 1);
    checks++; if (bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL fullpop_drop got %0d want 1", bus.drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      logic [63:0] want;
      want = (i < 7) ? exp[i+1] : extra;
      checks++; if (bus.ipg_mem_valid !== 1'b1 || bus.ipg_mem_chunk !== want) begin errors++; $display("FAIL drain%0d got %0b/%h want 1/%h", i, bus.ipg_mem_valid, bus.ipg_mem_chunk, want); end
      drive(0, 2'b01, IDLE, 0, 1);
    end
    checks++; if (bus.ipg_mem_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", bus.ipg_mem_valid); end
  endtask

  task automatic test_bad_header();
    logic [63:0] d1, d2;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    do_reset();
    drive(1, 2'b11, d1);
    checks++; if (bus.proced_encoded_rx_hdr !== 2'b11 || bus.proced_encoded_rx_data !== d1) begin errors++; $display("FAIL badhdr_pass got %0h/%h want 3/%h", bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, d1); end
    drive(1, 2'b10, d2);
    checks++; if (bus.proced_encoded_rx_hdr !== 2'b10 || bus.proced_encoded_rx_data !== d2) begin errors++; $display("FAIL idledata_pass got %0h/%h want 2/%h", bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, d2); end
    checks++; if (bus.frame_err_cnt !== 16'd2) begin errors++; $display("FAIL badhdr_err got %0d want 2", bus.frame_err_cnt); end
  endtask

  task automatic test_async_reset();
    logic [63:0] p;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 2'b01, rnd_block(8'hA5));
    drive(1, 2'b01, rnd_block(8'h78));
    #2;
    reset = 1;
    #1;
    checks++; if (bus.proced_encoded_rx_valid !== 1'b0 || bus.proced_encoded_rx_hdr !== 2'b01 || bus.proced_encoded_rx_data !== IDLE) begin errors++; $display("FAIL areset_out got %0b/%0h/%h want 0/1/%h", bus.proced_encoded_rx_valid, bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, IDLE); end
    checks++; if (bus.ipg_req_valid !== 1'b0) begin errors++; $display("FAIL areset_fifo got %0b want 0", bus.ipg_req_valid); end
    #2;
    reset = 0;
    model_reset();
    p = rnd_block(8'hA5);
    drive(1, 2'b01, p);
    checks++; if (bus.proced_encoded_rx_data !== IDLE || bus.ipg_req_valid !== 1'b1 || bus.ipg_req_chunk !== p) begin errors++; $display("FAIL areset_extract got %h/%0b/%h want %h/1/%h", bus.proced_encoded_rx_data, bus.ipg_req_valid, bus.ipg_req_chunk, IDLE, p); end
  endtask

  task automatic test_random();
    logic [7:0] starts [3];
    logic [7:0] terms [8];
    starts = '{8'h78, 8'h33, 8'h66};
    terms  = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic [1:0]  h;
      logic [63:0] d;
      bit v;
      v = ($urandom_range(0, 9) != 0);
      h = 2'b01;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       d = IDLE;
        1:       d[7:0] = starts[$urandom_range(0, 2)];
        2:       d[7:0] = terms[$urandom_range(0, 7)];
        3, 4:    h = 2'b10;
        5, 9:    d[7:0] = 8'hA5;
        6:       d[7:0] = 8'h5A;
        7:       h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        default: ;
      endcase
      drive(v, h, d, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      checks++; if (bus.proced_encoded_rx_valid !== m_valid || bus.proced_encoded_rx_hdr !== m_hdr || bus.proced_encoded_rx_data !== m_data) begin errors++; $display("FAIL rnd_out%0d got %0b/%0h/%h want %0b/%0h/%h", n, bus.proced_encoded_rx_valid, bus.proced_encoded_rx_hdr, bus.proced_encoded_rx_data, m_valid, m_hdr, m_data); end
      checks++; if (bus.ipg_req_valid !== (m_req.size() != 0) || (m_req.size() != 0 && bus.ipg_req_chunk !== m_req[0])) begin errors++; $display("FAIL rnd_req%0d got %0b/%h want %0d entries", n, bus.ipg_req_valid, bus.ipg_req_chunk, m_req.size()); end
      checks++; if (bus.ipg_mem_valid !== (m_mem.size() != 0) || (m_mem.size() != 0 && bus.ipg_mem_chunk !== m_mem[0])) begin errors++; $display("FAIL rnd_mem%0d got %0b/%h want %0d entries", n, bus.ipg_mem_valid, bus.ipg_mem_chunk, m_mem.size()); end
      checks++; if (bus.frame_err_cnt !== 16'(m_err) || bus.drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd_cnt%0d got %0d/%0d want %0d/%0d", n, bus.frame_err_cnt, bus.drop_cnt, m_err, m_drop); end
    end
  endtask

  initial begin
    bus.encoded_rx_valid = 0;
    bus.encoded_rx_hdr   = 2'b01;
    bus.encoded_rx_data  = IDLE;
    bus.ipg_req_ready    = 0;
    bus.ipg_mem_ready    = 0;
    model_reset();
    test_reset();
    test_extract();
    test_in_frame();
    test_mem_overflow_and_wrap();
    test_bad_header();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
